// File: rtl/perf_counter_uart_reporter.sv
// rtl/perf_counter_uart_reporter.sv - snapshots cycle/instr counters and sends a 10-byte 8N1 UART frame
module perf_counter_uart_reporter #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snapshot,
  input  logic [31:0] cycle_count,
  input  logic [31:0] instr_count,
  output logic        serial_out,
  output logic        busy,
  output logic        frame_done
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [3:0] LAST_BYTE = 4'd9;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [3:0]      byte_q, byte_d;
  logic [63:0]     snap_q, snap_d;
  logic            serial_q, serial_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      checksum;
  logic [7:0]      cur_byte;
  logic [3:0]      byte_m1;
  logic            baud_wrap;

  always_comb begin
    checksum = '0;
    for (int i = 0; i < 8; i++) begin
      checksum = checksum ^ snap_q[8*i +: 8];
    end
  end

  // snap_q holds {instr, cycle}, so frame bytes 1..8 are its bytes 0..7 in order
  always_comb begin
    byte_m1 = byte_q - 4'd1;
    case (byte_q)
      4'd0:    cur_byte = 8'hA5;
      4'd9:    cur_byte = checksum;
      default: cur_byte = snap_q[{byte_m1[2:0], 3'b000} +: 8];
    endcase
  end

  assign baud_wrap = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + CW'(1);
    bit_d    = bit_q;
    byte_d   = byte_q;
    snap_d   = snap_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        baud_d   = '0;
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (snapshot) begin
          snap_d   = {instr_count, cycle_count};
          byte_d   = '0;
          bit_d    = '0;
          state_d  = START;
          serial_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_d   = '0;
          bit_d    = '0;
          state_d  = DATA;
          serial_d = cur_byte[0];
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            bit_d    = bit_q + 3'd1;
            serial_d = cur_byte[bit_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (byte_q < LAST_BYTE) begin
            byte_d   = byte_q + 4'd1;
            state_d  = START;
            serial_d = 1'b0;
          end else begin
            state_d  = IDLE;
            serial_d = 1'b1;
            busy_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        baud_d   = '0;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
    // registered so the pulse lands on the final cycle of the last stop bit
    done_d = (state_d == STOP) && (byte_d == LAST_BYTE) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      snap_q   <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      snap_q   <= snap_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_perf_counter_uart_reporter.sv
// tb/tb_perf_counter_uart_reporter.sv - self-checking bench for perf_counter_uart_reporter
module tb_perf_counter_uart_reporter;

  localparam int CF = 1000;
  localparam int BR = 100;
  localparam int S  = CF / BR;
  localparam int FL = 100 * S;

  logic        clk = 1'b0;
  logic        rst;
  logic        snapshot;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;
  logic        serial_out;
  logic        busy;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perf_counter_uart_reporter #(
    .CLOCK_FREQ(CF),
    .BAUD_RATE (BR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .snapshot   (snapshot),
    .cycle_count(cycle_count),
    .instr_count(instr_count),
    .serial_out (serial_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  function automatic logic [79:0] model_frame(input logic [31:0] cv, input logic [31:0] iv);
    logic [79:0] f;
    logic [7:0]  x;
    x = 8'h00;
    f = '0;
    f[7:0] = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      f[8*(1+k) +: 8] = cv[8*k +: 8];
      f[8*(5+k) +: 8] = iv[8*k +: 8];
      x = x ^ cv[8*k +: 8] ^ iv[8*k +: 8];
    end
    f[79:72] = x;
    return f;
  endfunction

  // Expected line level j cycles after the accepting edge (j = 1..FL)
  function automatic logic model_line(input logic [79:0] f, input int j);
    int k;
    int b;
    int i;
    k = (j - 1) / S;
    b = k / 10;
    i = k % 10;
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return f[8*b + i - 1];
  endfunction

  task automatic do_frame(input logic [31:0] cv, input logic [31:0] iv,
                          input bit incr, input bit rej, input string nm);
    logic [79:0] f;
    logic        ln [FL+2];
    logic        bz [FL+2];
    logic        dn [FL+2];
    logic [7:0]  got;
    logic        fr_ok;
    int          first_bad;
    int          busy_bad;
    int          done_bad;
    f = model_frame(cv, iv);
    total++;
    if (serial_out !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_pre_idle serial=%b busy=%b required serial=1 busy=0", nm, serial_out, busy);
    end
    cycle_count = cv;
    instr_count = iv;
    snapshot    = 1'b1;
    for (int j = 1; j <= FL + 1; j++) begin
      @(negedge clk);
      ln[j] = serial_out;
      bz[j] = busy;
      dn[j] = frame_done;
      snapshot = rej && (j == 500 || j == FL);
      if (incr) cycle_count = cycle_count + 32'd1;
    end

    total++;
    if (ln[1] !== 1'b0 || bz[1] !== 1'b1) begin
      bad++;
      $display("FAIL %s_start_latency serial=%b busy=%b one cycle after pulse required serial=0 busy=1", nm, ln[1], bz[1]);
    end

    first_bad = 0;
    for (int j = 1; j <= FL; j++) begin
      if (first_bad == 0 && ln[j] !== model_line(f, j)) first_bad = j;
    end
    total++;
    if (first_bad != 0) begin
      bad++;
      $display("FAIL %s_line_shape at cycle %0d got %b required %b", nm, first_bad, ln[first_bad], model_line(f, first_bad));
    end

    fr_ok = 1'b1;
    for (int b = 0; b < 10; b++) begin
      got = 8'h00;
      for (int i = 0; i < 8; i++) got[i] = ln[(b*10 + 1 + i)*S + S/2 + 1];
      if (ln[(b*10)*S + S/2 + 1] !== 1'b0 || ln[(b*10 + 9)*S + S/2 + 1] !== 1'b1) fr_ok = 1'b0;
      total++;
      if (got !== f[8*b +: 8]) begin
        bad++;
        $display("FAIL %s_byte%0d got %02h required %02h", nm, b, got, f[8*b +: 8]);
      end
    end
    total++;
    if (!fr_ok) begin
      bad++;
      $display("FAIL %s_framing start/stop bits got bad levels required start=0 stop=1", nm);
    end

    busy_bad = 0;
    done_bad = 0;
    for (int j = 1; j <= FL + 1; j++) begin
      if (bz[j] !== ((j <= FL) ? 1'b1 : 1'b0)) busy_bad++;
      if (dn[j] !== ((j == FL) ? 1'b1 : 1'b0)) done_bad++;
    end
    total++;
    if (busy_bad != 0) begin
      bad++;
      $display("FAIL %s_busy_window %0d wrong cycles required 0", nm, busy_bad);
    end
    total++;
    if (done_bad != 0) begin
      bad++;
      $display("FAIL %s_frame_done_timing %0d wrong cycles (done at FL=%0d got %b) required 0", nm, done_bad, FL, dn[FL]);
    end
    total++;
    if (ln[FL+1] !== 1'b1) begin
      bad++;
      $display("FAIL %s_post_idle serial=%b required 1", nm, ln[FL+1]);
    end
  endtask

  task automatic test_reset();
    int errs;
    rst         = 1'b0;
    snapshot    = 1'b0;
    cycle_count = '0;
    instr_count = '0;
    errs = 0;
    repeat (3) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL reset_hold %0d bad cycles serial=%b busy=%b done=%b required 1/0/0", errs, serial_out, busy, frame_done);
    end
    rst = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      total++;
      if (serial_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d serial=%b busy=%b done=%b required 1/0/0", c, serial_out, busy, frame_done);
      end
    end
  endtask

  task automatic test_basic_frame();
    do_frame(32'h12345678, 32'h00000010, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 2; n++) begin
      do_frame($urandom, $urandom, 1'b0, 1'b0, "random");
      repeat ($urandom_range(1, 7)) @(negedge clk);
    end
  endtask

  task automatic test_snapshot_isolation();
    do_frame($urandom, $urandom, 1'b1, 1'b0, "isolation");
    @(negedge clk);
  endtask

  task automatic test_busy_rejection();
    int errs;
    do_frame($urandom, $urandom, 1'b0, 1'b1, "reject");
    errs = 0;
    for (int c = 0; c < 4 * S; c++) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL reject_no_second_frame %0d non-idle cycles required 0", errs);
    end
  endtask

  task automatic test_back_to_back();
    do_frame($urandom, $urandom, 1'b0, 1'b0, "b2b_first");
    do_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic saw_done;
    saw_done    = 1'b0;
    cycle_count = 32'h00000000;
    instr_count = $urandom;
    snapshot    = 1'b1;
    for (int j = 1; j <= 347; j++) begin
      @(negedge clk);
      snapshot = 1'b0;
      if (frame_done === 1'b1) saw_done = 1'b1;
    end
    total++;
    if (serial_out !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre serial=%b busy=%b required serial=0 busy=1", serial_out, busy);
    end
    #1 rst = 1'b0;
    #1;
    total++;
    if (serial_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async serial=%b busy=%b done=%b required 1/0/0", serial_out, busy, frame_done);
    end
    repeat (5) begin
      @(negedge clk);
      if (frame_done === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b1;
    for (int c = 0; c < 2 * FL; c++) begin
      @(negedge clk);
      if (frame_done === 1'b1 || busy !== 1'b0) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL midreset_no_done got frame activity after reset required none");
    end
    do_frame($urandom, $urandom, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_random_frames();
    test_snapshot_isolation();
    test_busy_rejection();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
